// File: rtl/alu_op_sequencer.sv
// Control stage for a 16-bit combinational ALU: small register file, request handshake,
// one-cycle ALU execute, writeback and a held response until the consumer takes it.
module alu_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [REG_AW-1:0] req_rs1,
    input  logic [REG_AW-1:0] req_rs2,
    input  logic              load_en,
    input  logic [REG_AW-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [2:0]        alu_select,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                         state;
    logic [REG_AW-1:0]              rd_q;
    logic [NREGS-1:0][DATA_W-1:0]   regs;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_q       <= '0;
            regs       <= '0;
            alu_select <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en)
                        regs[load_addr] <= load_data;
                    if (req_valid) begin
                        // A same-edge load to a source register is forwarded into the operand.
                        alu_select <= req_op;
                        alu_a      <= (load_en && load_addr == req_rs1) ? load_data : regs[req_rs1];
                        alu_b      <= (load_en && load_addr == req_rs2) ? load_data : regs[req_rs2];
                        rd_q       <= req_rd;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    regs[rd_q] <= alu_result;
                    rsp_data   <= alu_result;
                    rsp_zero   <= alu_flag;
                    rsp_valid  <= 1'b1;
                    op_count   <= op_count + 16'd1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer with a behavioural ALU and a
// register-file/op-count reference model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [1:0]  req_rd, req_rs1, req_rs2;
    logic        load_en;
    logic [1:0]  load_addr;
    logic [15:0] load_data;
    logic [2:0]  alu_select;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_flag;
    logic        rsp_valid, rsp_ready, rsp_zero;
    logic [15:0] rsp_data, op_count;

    logic [15:0] mregs [4];
    logic [15:0] mcount;
    int compared = 0;
    int mismatched = 0;

    alu_op_sequencer #(.DATA_W(16), .NREGS(4), .REG_AW(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a + 16'd1;
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    // Stand-in for the external ALU.
    always_comb begin
        alu_result = alu_fn(alu_select, alu_a, alu_b);
        alu_flag   = (alu_result == 16'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
        mregs[a] = d;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ld, input logic [1:0] la,
                         input logic [15:0] ld_d, input int hold);
        logic [15:0] a, b, r;
        chk("req_ready_idle", 32'(req_ready), 1);
        if (ld) mregs[la] = ld_d;
        a = mregs[rs1];
        b = mregs[rs2];
        r = alu_fn(op, a, b);
        req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        load_en = ld; load_addr = la; load_data = ld_d;
        tick();
        req_valid = 1'b0; load_en = 1'b0;
        chk("alu_a", 32'(alu_a), 32'(a));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("alu_select", 32'(alu_select), 32'(op));
        chk("req_ready_exec", 32'(req_ready), 0);
        chk("rsp_valid_exec", 32'(rsp_valid), 0);
        tick();
        mregs[rd] = r;
        mcount = mcount + 16'd1;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_data", 32'(rsp_data), 32'(r));
        chk("rsp_zero", 32'(rsp_zero), 32'(r == 16'd0));
        chk("op_count", 32'(op_count), 32'(mcount));
        for (int i = 0; i < hold; i++) begin
            load_en = 1'b1; load_addr = rd; load_data = ~r;
            tick();
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(r));
            chk("hold_ready", 32'(req_ready), 0);
        end
        load_en = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("req_ready_back", 32'(req_ready), 1);
    endtask

    // Reading a register back: OR with itself into itself leaves it unchanged.
    task automatic peek(input logic [1:0] r);
        do_op(3'd4, r, r, r, 1'b0, 2'd0, 16'd0, 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 16'd0;
        mcount = 16'd0;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_zero", 32'(rsp_zero), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        @(negedge clk) reset = 1'b0;

        // Basic add
        load(2'd0, 16'd5);
        load(2'd1, 16'd3);
        do_op(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 16'd0, 0);
        peek(2'd2);

        // Subtract to zero, then R0+R0
        load(2'd0, 16'h1234);
        load(2'd1, 16'h1234);
        do_op(3'd1, 2'd0, 2'd0, 2'd1, 1'b0, 2'd0, 16'd0, 0);
        do_op(3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 16'd0, 0);

        // Same-edge load bypass into rs2
        load(2'd0, 16'd1);
        do_op(3'd0, 2'd2, 2'd0, 2'd1, 1'b1, 2'd1, 16'd7, 0);
        peek(2'd1);

        // Back-pressure with ignored loads, then confirm rd was not overwritten
        do_op(3'd2, 2'd3, 2'd2, 2'd1, 1'b0, 2'd0, 16'd0, 5);
        peek(2'd3);

        // Increment wraps to zero
        load(2'd0, 16'hFFFF);
        do_op(3'd5, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 16'd0, 0);
        peek(2'd0);

        // Reset while in EXEC drops the op
        load(2'd1, 16'h00AA);
        req_valid = 1'b1; req_op = 3'd0; req_rd = 2'd2; req_rs1 = 2'd1; req_rs2 = 2'd1;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_op_count", 32'(op_count), 0);
        chk("midrst_alu_a", 32'(alu_a), 0);
        chk("midrst_req_ready", 32'(req_ready), 1);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 16'd0;
        mcount = 16'd0;
        for (int i = 0; i < 4; i++) peek(2'(i));

        // Randomized ops with occasional bypass loads and back-pressure
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) load(2'($urandom), 16'($urandom));
            do_op(3'($urandom_range(7)), 2'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom_range(3) == 0), 2'($urandom), 16'($urandom), int'($urandom_range(2)));
        end
        for (int i = 0; i < 4; i++) peek(2'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
